// File: rtl/prog_loader.sv
// prog_loader: host-side sequencer for a single-cycle core.
// Loads a program from a valid/ready stream into instruction memory at word
// addresses 0,1,2,..., pulses the core's start, then times the run until the
// core raises done or the run reaches MAX_CYCLES.
//
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   load_req, run_req       one-cycle requests (load+run / re-run only)
//   in_valid/in_data/in_last/in_ready   program word stream
//   im_wen/im_waddr/im_wdata            registered instruction-memory write
//   start, done             handshake with the core
//   busy                    high outside IDLE and FINISH
//   prog_len                words written by the last load
//   cycle_count             run-phase cycles until done
//   run_done, timeout, overflow         sticky status flags
module prog_loader #(
  parameter int ADDR_WIDTH   = 12,
  parameter int INSTR_WIDTH  = 9,
  parameter int START_CYCLES = 2,
  parameter int MAX_CYCLES   = 65535
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_req,
  input  logic                   run_req,
  input  logic                   in_valid,
  input  logic [INSTR_WIDTH-1:0] in_data,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic                   im_wen,
  output logic [ADDR_WIDTH-1:0]  im_waddr,
  output logic [INSTR_WIDTH-1:0] im_wdata,
  output logic                   start,
  input  logic                   done,
  output logic                   busy,
  output logic [ADDR_WIDTH:0]    prog_len,
  output logic [31:0]            cycle_count,
  output logic                   run_done,
  output logic                   timeout,
  output logic                   overflow
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_RUN, S_FINISH
  } state_t;

  localparam int                   SC_W       = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [SC_W-1:0]      START_LAST = SC_W'(START_CYCLES - 1);
  localparam logic [31:0]          MAX_COUNT  = 32'(MAX_CYCLES);
  localparam logic [ADDR_WIDTH-1:0] TOP_ADDR  = '1;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [SC_W-1:0]         start_cnt_q;
  // Set once the final word is accepted; closes in_ready while the last
  // write is still being issued.
  logic                    load_end_q;

  logic go_load, go_run, accept, final_word, at_top;

  assign at_top = (addr_q == TOP_ADDR);

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    start      = 1'b0;
    busy       = 1'b0;
    go_load    = 1'b0;
    go_run     = 1'b0;
    accept     = 1'b0;
    final_word = 1'b0;
    case (state_q)
      S_IDLE, S_FINISH: begin
        // load_req has priority; a re-run needs a non-empty program.
        if (load_req) begin
          state_d = S_LOAD;
          go_load = 1'b1;
        end else if (run_req && prog_len != '0) begin
          state_d = S_START;
          go_run  = 1'b1;
        end
      end
      S_LOAD: begin
        busy       = 1'b1;
        in_ready   = !load_end_q;
        accept     = in_valid && !load_end_q;
        final_word = accept && (in_last || at_top);
        // The final write is on the bus this cycle; start follows it.
        if (load_end_q) state_d = S_START;
      end
      S_START: begin
        busy  = 1'b1;
        start = 1'b1;
        if (start_cnt_q == START_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (done || cycle_count == MAX_COUNT) state_d = S_FINISH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q      <= '0;
      start_cnt_q <= '0;
      load_end_q  <= 1'b0;
      im_wen      <= 1'b0;
      im_waddr    <= '0;
      im_wdata    <= '0;
      prog_len    <= '0;
      cycle_count <= '0;
      run_done    <= 1'b0;
      timeout     <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      im_wen      <= accept;
      start_cnt_q <= (state_q == S_START) ? start_cnt_q + 1'b1 : '0;

      if (accept) begin
        im_waddr <= addr_q;
        im_wdata <= in_data;
        prog_len <= prog_len + 1'b1;
        // No wrap-around: the top address is the last one ever written.
        if (!at_top)             addr_q   <= addr_q + 1'b1;
        if (at_top && !in_last)  overflow <= 1'b1;
      end
      if (final_word) load_end_q <= 1'b1;

      if (state_q == S_RUN) begin
        if (done) begin
          run_done <= 1'b1;
        end else if (cycle_count == MAX_COUNT) begin
          run_done <= 1'b1;
          timeout  <= 1'b1;
        end else begin
          cycle_count <= cycle_count + 1'b1;
        end
      end

      if (go_load) begin
        addr_q      <= '0;
        load_end_q  <= 1'b0;
        prog_len    <= '0;
        cycle_count <= '0;
        run_done    <= 1'b0;
        timeout     <= 1'b0;
        overflow    <= 1'b0;
      end
      if (go_run) begin
        cycle_count <= '0;
        run_done    <= 1'b0;
        timeout     <= 1'b0;
      end
    end
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Host-side sequencer on the other end of the core's instruction-fetch and start/done interface.
- Writes a program from a 9-bit valid/ready stream into instruction memory at word addresses 0,1,2,...
- Then drives `start` to the single-cycle core, waits for the core's `done`, counts execution cycles and reports status.
- Sits between the testbench/host and the core plus instruction memory.

Parameters:
- ADDR_WIDTH, 12, instruction memory address width (matches the core's PC width).
- INSTR_WIDTH, 9, instruction word width.
- START_CYCLES, 2, number of cycles `start` is held high before the run phase (minimum 1).
- MAX_CYCLES, 65535, run-phase cycle limit before timeout; `cycle_count` width is 32.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- load_req  in  1  one-cycle request: load a new program, then run it.
- run_req  in  1  one-cycle request: re-run the already-loaded program without loading.
- in_valid  in  1  stream word valid.
- in_data  in  INSTR_WIDTH  stream instruction word.
- in_last  in  1  marks the final word of the program.
- in_ready  out  1  loader accepts a stream word this cycle.
- im_wen  out  1  instruction memory write enable.
- im_waddr  out  ADDR_WIDTH  instruction memory write address.
- im_wdata  out  INSTR_WIDTH  instruction memory write data.
- start  out  1  to core `start` (the core holds PC at 0 while high).
- done  in  1  from core: program finished.
- busy  out  1  high in any state other than IDLE and FINISH.
- prog_len  out  ADDR_WIDTH+1  number of words written by the last load.
- cycle_count  out  32  run-phase cycles until `done`.
- run_done  out  1  sticky: run completed (normally or by timeout).
- timeout  out  1  sticky: run ended by reaching MAX_CYCLES.
- overflow  out  1  sticky: load ended at the top address without `in_last`.

Behaviour:
- Reset (async, immediate): state IDLE; every output 0; address counter 0. Reset mid-load or mid-run aborts the operation. Memory contents already written are not cleared.
- States: IDLE, LOAD, START, RUN, FINISH.

IDLE / FINISH:
- `load_req` -> LOAD. This clears the address counter, `prog_len`, `cycle_count`, `run_done`, `timeout` and `overflow`.
- `run_req` (without `load_req`) -> START. This clears `cycle_count`, `run_done` and `timeout`; `prog_len` is kept.
- `run_req` while `prog_len`==0 is ignored.
- If `load_req` and `run_req` arrive together, `load_req` wins.
- `load_req` and `run_req` are ignored in LOAD, START and RUN.

LOAD:
- `in_ready`=1. A word is accepted when `in_valid`&&`in_ready`.
- Write is registered. The cycle after acceptance: `im_wen`=1, `im_waddr`=counter, `im_wdata`=word. The counter then increments and `prog_len` increments.
- `im_wen` is 0 in every other cycle.
- Accepting a word with `in_last`=1, or accepting the word at address 2^ADDR_WIDTH-1, ends the load: `in_ready` drops the next cycle and the state goes to START once the final write has issued.
- At the top address with `in_last`=0, `overflow` is set. There is no wrap-around.
- A `in_valid` gap holds LOAD indefinitely.

START:
- `start`=1 for exactly START_CYCLES cycles, then `start`=0 -> RUN.
- `done` is ignored in START, because the core's `done` is stale until it restarts.

RUN:
- Each cycle: if `done`=1 -> FINISH, set `run_done`, freeze `cycle_count`.
- Else if `cycle_count`==MAX_CYCLES -> FINISH, set `run_done` and `timeout`.
- Else `cycle_count`++.
- If `done` is seen in the first RUN cycle, `cycle_count`=0.

Other rules:
- `busy` is combinational from the state.
- `in_ready` is 0 outside LOAD.
- The counter and `prog_len` are unsigned; `prog_len` is max 2^ADDR_WIDTH.

Test Plan:
- Reset check: assert reset mid-cycle -> all outputs 0 immediately; release, idle 5 cycles -> `busy`=0, `im_wen`=0.
- Normal load and run: `load_req`, stream 0x1A0,0x0C3,0x1FF with `in_last` on the third word, `in_valid` continuous.
  - Writes at addresses 0,1,2 with matching data, each one cycle after acceptance; `prog_len`=3.
  - `start` high for 2 cycles; `done` raised on the 10th RUN cycle -> `cycle_count`=9, `run_done`=1, `timeout`=0, `busy`=0.
- Backpressure and request filtering: `in_valid` toggles 1,0,0,1 -> exactly 2 writes, to addresses 0 and 1, no duplicates. `load_req` pulsed mid-LOAD is ignored.
- Re-run: from FINISH, pulse `run_req` -> no `im_wen`, `prog_len` unchanged, `start` pulse repeats, `cycle_count` restarts from 0. `done` held high during START is ignored.
- Timeout: set MAX_CYCLES=20, never assert `done` -> FINISH with `cycle_count`=20, `timeout`=1, `run_done`=1.
- Overflow and abort: set ADDR_WIDTH=3, stream 8 words with `in_last`=0 -> writes at 0..7, `overflow`=1, `prog_len`=8, then `start` asserts. Separately, reset during RUN -> IDLE, `start`=0.
